// File: rtl/sm_datapath_if.sv
// rtl/sm_datapath_if.sv - control strobes, operands and product handshake of the multiplier datapath
interface sm_datapath_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0]   md_in;
  logic [WIDTH-1:0]   mr_in;
  logic               mdld;
  logic               mrld;
  logic               rsclear;
  logic               rsload;
  logic               rsshr;
  logic               done;
  logic [WIDTH-1:0]   mr;
  logic [2*WIDTH-1:0] prod;
  logic               prod_valid;
  logic               prod_ready;
  logic               ovf;

  modport master (
    output md_in, mr_in, mdld, mrld, rsclear, rsload, rsshr, done, prod_ready,
    input  mr, prod, prod_valid, ovf
  );

  modport slave (
    input  md_in, mr_in, mdld, mrld, rsclear, rsload, rsshr, done, prod_ready,
    output mr, prod, prod_valid, ovf
  );
endinterface

// File: rtl/sm_datapath.sv
// rtl/sm_datapath.sv - shift-add multiplier datapath: md/mr/rs registers and product output
// Defining SM_DP_RESULT_BUF_EN adds a registered 1-entry valid/ready result buffer.
module sm_datapath #(
  parameter int WIDTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  sm_datapath_if.slave dp
);
  localparam int W = WIDTH;

  logic [W-1:0] md_q, md_d;
  logic [W-1:0] mr_q, mr_d;
  logic [2*W:0] rs_q, rs_d;
  logic [W:0]   sum;

  // rs[2W] is the carry of the upper-half add; the following shift folds it back in
  always_comb begin
    md_d = dp.mdld ? dp.md_in : md_q;
    mr_d = dp.mrld ? dp.mr_in : mr_q;
    sum  = {1'b0, rs_q[2*W-1:W]} + {1'b0, md_q};
    rs_d = rs_q;
    if (dp.rsclear)     rs_d = '0;
    else if (dp.rsload) rs_d = {sum, rs_q[W-1:0]};
    else if (dp.rsshr)  rs_d = rs_q >> 1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      md_q <= '0;
      mr_q <= '0;
      rs_q <= '0;
    end else begin
      md_q <= md_d;
      mr_q <= mr_d;
      rs_q <= rs_d;
    end
  end

  assign dp.mr = mr_q;

`ifdef SM_DP_RESULT_BUF_EN
  logic [2*W-1:0] prod_q, prod_d;
  logic           prod_valid_q, prod_valid_d;
  logic           ovf_q, ovf_d;
  logic           take;

  // A new result is taken when the slot is empty or being drained this cycle
  always_comb begin
    take         = dp.done & (~prod_valid_q | dp.prod_ready);
    prod_d       = take ? rs_q[2*W-1:0] : prod_q;
    prod_valid_d = prod_valid_q;
    if (take)                            prod_valid_d = 1'b1;
    else if (prod_valid_q & dp.prod_ready) prod_valid_d = 1'b0;
    ovf_d        = ovf_q | (dp.done & prod_valid_q & ~dp.prod_ready);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q       <= '0;
      prod_valid_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      prod_q       <= prod_d;
      prod_valid_q <= prod_valid_d;
      ovf_q        <= ovf_d;
    end
  end

  assign dp.prod       = prod_q;
  assign dp.prod_valid = prod_valid_q;
  assign dp.ovf        = ovf_q;
`else
  logic unused_prod_ready;
  assign unused_prod_ready = dp.prod_ready;

  assign dp.prod       = rs_q[2*W-1:0];
  assign dp.prod_valid = dp.done;
  assign dp.ovf        = 1'b0;
`endif
endmodule

// File: tb/tb_sm_datapath.sv
// tb/tb_sm_datapath.sv - directed bench for sm_datapath, both with and without SM_DP_RESULT_BUF_EN
module tb_sm_datapath;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  sm_datapath_if #(.WIDTH(4)) dif ();

  sm_datapath #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .dp  (dif.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    dif.mdld = 1'b0; dif.mrld = 1'b0; dif.rsclear = 1'b0;
    dif.rsload = 1'b0; dif.rsshr = 1'b0; dif.done = 1'b0;
  endtask

  task automatic step();
    @(negedge clk);
    idle();
    #1;
  endtask

  // Plays the controller sequence up to and including raising done
  task automatic run_mult(input logic [3:0] a, input logic [3:0] b);
    dif.md_in = a; dif.mr_in = b;
    dif.mdld = 1'b1; dif.mrld = 1'b1; dif.rsclear = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      if (b[i]) begin
        dif.rsload = 1'b1;
        step();
      end
      dif.rsshr = 1'b1;
      step();
    end
    dif.done = 1'b1;
    #1;
  endtask

  task automatic check_product(input string tag, input logic [7:0] exp, input logic [3:0] b);
    chk({tag, "_mr"}, dif.mr, b);
    chk({tag, "_carry"}, dut.rs_q[8], 0);
`ifdef SM_DP_RESULT_BUF_EN
    step();
    chk({tag, "_prod"}, dif.prod, exp);
    chk({tag, "_valid"}, dif.prod_valid, 1);
`else
    chk({tag, "_prod"}, dif.prod, exp);
    chk({tag, "_valid"}, dif.prod_valid, 1);
    step();
    chk({tag, "_valid_low"}, dif.prod_valid, 0);
`endif
  endtask

  initial begin
    idle();
    dif.md_in = '0; dif.mr_in = '0; dif.prod_ready = 1'b1;
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_md", dut.md_q, 0);
    chk("rst_mr", dif.mr, 0);
    chk("rst_rs", dut.rs_q, 0);
    chk("rst_prod", dif.prod, 0);
    chk("rst_valid", dif.prod_valid, 0);
    chk("rst_ovf", dif.ovf, 0);

    run_mult(4'd5, 4'd3);
    check_product("m5x3", 8'd15, 4'd3);

    run_mult(4'd15, 4'd15);
    check_product("m15x15", 8'hE1, 4'd15);

    run_mult(4'd9, 4'd0);
    check_product("m9x0", 8'd0, 4'd0);

    run_mult(4'd0, 4'd11);
    check_product("m0x11", 8'd0, 4'd11);
    step(); step();

`ifdef SM_DP_RESULT_BUF_EN
    dif.prod_ready = 1'b0;
    run_mult(4'd2, 4'd3);
    step();
    chk("buf_first_prod", dif.prod, 6);
    chk("buf_first_valid", dif.prod_valid, 1);
    chk("buf_first_ovf", dif.ovf, 0);
    run_mult(4'd5, 4'd7);
    step();
    chk("buf_drop_prod", dif.prod, 6);
    chk("buf_drop_valid", dif.prod_valid, 1);
    chk("buf_drop_ovf", dif.ovf, 1);
    dif.prod_ready = 1'b1;
    step();
    chk("buf_drain_valid", dif.prod_valid, 0);
    chk("buf_drain_prod", dif.prod, 6);
    chk("buf_ovf_sticky", dif.ovf, 1);
    dif.prod_ready = 1'b0;
    run_mult(4'd2, 4'd3);
    step();
    chk("buf_refill_prod", dif.prod, 6);
    run_mult(4'd5, 4'd7);
    dif.prod_ready = 1'b1;
    step();
    chk("buf_swap_prod", dif.prod, 35);
    chk("buf_swap_valid", dif.prod_valid, 1);
    step();
    chk("buf_swap_drain", dif.prod_valid, 0);
`else
    dif.prod_ready = 1'b0;
    run_mult(4'd6, 4'd6);
    chk("nobuf_ready_ignored", dif.prod_valid, 1);
    chk("nobuf_prod", dif.prod, 36);
    chk("nobuf_ovf", dif.ovf, 0);
    step();
    dif.prod_ready = 1'b1;
`endif

    dif.md_in = 4'hA; dif.mdld = 1'b1; dif.rsclear = 1'b1;
    step();
    dif.rsload = 1'b1;
    step();
    chk("rs_load_a0", dut.rs_q, 9'h0A0);
    for (int i = 0; i < 4; i++) begin
      dif.rsshr = 1'b1;
      step();
    end
    dif.rsload = 1'b1;
    step();
    chk("rs_aa", dut.rs_q, 9'h0AA);
    dif.rsload = 1'b1; dif.rsshr = 1'b1;
    step();
    chk("rs_load_over_shr", dut.rs_q, 9'h14A);
    dif.rsclear = 1'b1; dif.rsload = 1'b1; dif.rsshr = 1'b1;
    step();
    chk("rs_clear_wins", dut.rs_q, 0);

    dif.md_in = 4'd7; dif.mr_in = 4'd13;
    dif.mdld = 1'b1; dif.mrld = 1'b1; dif.rsclear = 1'b1;
    step();
    dif.rsload = 1'b1;
    step();
    dif.rsshr = 1'b1;
    step();
    dif.rsshr = 1'b1;
    step();
    chk("mid_rs", dut.rs_q, 9'h01C);
    dif.done = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle();
    #1;
    chk("midrst_md", dut.md_q, 0);
    chk("midrst_mr", dif.mr, 0);
    chk("midrst_rs", dut.rs_q, 0);
    chk("midrst_prod", dif.prod, 0);
    chk("midrst_valid", dif.prod_valid, 0);
    chk("midrst_ovf", dif.ovf, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
